// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the issue sequencer: opcode/ext codes, FSM states, ALU selects, PSR bit positions.
// The optional LSHI decode is enabled with the RF_ISSUE_SHIFT_EN macro.
package cpu_isa_pkg;

  localparam int WIDTH = 16;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LSHI  = 4'b1000;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  // Immediate forms reuse the R-type ext code as their opcode.
  localparam logic [3:0] EXT_AND = 4'b0001;
  localparam logic [3:0] EXT_OR  = 4'b0010;
  localparam logic [3:0] EXT_XOR = 4'b0011;
  localparam logic [3:0] EXT_ADD = 4'b0101;
  localparam logic [3:0] EXT_SUB = 4'b1001;
  localparam logic [3:0] EXT_CMP = 4'b1011;
  localparam logic [3:0] EXT_MOV = 4'b1101;
  localparam logic [3:0] EXT_SHL = 4'b0000;
  localparam logic [3:0] EXT_SHR = 4'b0001;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} issueStateT;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_PASS, ALU_CMP, ALU_SHL, ALU_SHR
  } aluOpT;

  function automatic logic [WIDTH-1:0] extendImm(input logic [7:0] imm, input logic signExt);
    return signExt ? {{(WIDTH-8){imm[7]}}, imm} : {{(WIDTH-8){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: a is the Rdest operand, b the Rsrc/immediate operand.
// Produces the 16-bit result and {N,Z,F,L,C}.
module alu_core
  import cpu_isa_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  aluOpT            op,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic signed [WIDTH-1:0] aS;
  logic signed [WIDTH-1:0] bS;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign aS   = a;
  assign bS   = b;

  always_comb begin
    result = '0;
    flags  = '0;
    case (op)
      ALU_ADD: begin
        result        = sum[WIDTH-1:0];
        flags[FLAG_C] = sum[WIDTH];
        flags[FLAG_F] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result        = diff[WIDTH-1:0];
        flags[FLAG_C] = diff[WIDTH];
        flags[FLAG_F] = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_PASS: result = b;
      ALU_CMP:  result = diff[WIDTH-1:0];
      ALU_SHL:  result = a << b[3:0];
      ALU_SHR:  result = a >> b[3:0];
      default:  result = '0;
    endcase
    // CMP reports relations between the operands instead of properties of the result.
    if (op == ALU_CMP) begin
      flags[FLAG_Z] = (a == b);
      flags[FLAG_N] = (aS < bS);
      flags[FLAG_L] = (a < b);
    end else begin
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_N] = result[WIDTH-1];
    end
  end

endmodule

// File: rtl/rf_issue_ctrl.sv
// Four-cycle issue/writeback sequencer feeding the RegFile and PSR (IDLE->DECODE->EXECUTE->WRITEBACK).
// Define RF_ISSUE_SHIFT_EN to decode op=1000 as LSHI; otherwise it retires as illegal.
module rf_issue_ctrl #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [WIDTH-1:0]  instr,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  input  logic [WIDTH-1:0]  rd_src,
  input  logic [WIDTH-1:0]  rd_dst,
  output logic              reg_write,
  output logic [WIDTH-1:0]  wr_data,
  output logic [4:0]        flags_out,
  output logic              flags_write,
  output logic              done,
  output logic              illegal
);
  import cpu_isa_pkg::*;

  issueStateT state, nextState;
  logic [WIDTH-1:0] instrQ;
  logic [WIDTH-1:0] resultQ;
  logic [4:0]       flagsQ;

  logic [3:0] op, ext, code;
  logic [7:0] imm8;
  aluOpT      aluOp;
  logic       useImm, opWrites, opFlags, opLegal;
  logic [WIDTH-1:0] immVal, opA, opB, aluResult;
  logic [4:0] aluFlags;

  assign op   = instrQ[15:12];
  assign ext  = instrQ[7:4];
  assign imm8 = instrQ[7:0];
  assign code = (op == OP_RTYPE) ? ext : op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (instr_valid) nextState = DECODE;
      DECODE:    nextState = EXECUTE;
      EXECUTE:   nextState = WRITEBACK;
      WRITEBACK: nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // Instruction, result and flags are data only; reset just returns the FSM to IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && instr_valid) instrQ <= instr;
    if (state == EXECUTE) begin
      resultQ <= aluResult;
      flagsQ  <= aluFlags;
    end
  end

  always_comb begin
    aluOp    = ALU_PASS;
    useImm   = 1'b0;
    immVal   = '0;
    opWrites = 1'b0;
    opFlags  = 1'b0;
    opLegal  = 1'b1;
    if (op == OP_LUI) begin
      useImm   = 1'b1;
      immVal   = {imm8, 8'h00};
      opWrites = 1'b1;
    end else if (op == OP_LSHI) begin
`ifdef RF_ISSUE_SHIFT_EN
      useImm   = 1'b1;
      immVal   = {{(WIDTH-4){1'b0}}, instrQ[3:0]};
      opWrites = 1'b1;
      if (ext == EXT_SHL)      aluOp = ALU_SHL;
      else if (ext == EXT_SHR) aluOp = ALU_SHR;
      else begin
        opLegal  = 1'b0;
        opWrites = 1'b0;
      end
`else
      opLegal = 1'b0;
`endif
    end else begin
      useImm = (op != OP_RTYPE);
      case (code)
        EXT_ADD: begin aluOp = ALU_ADD; opWrites = 1'b1; opFlags = 1'b1; immVal = extendImm(imm8, 1'b1); end
        EXT_SUB: begin aluOp = ALU_SUB; opWrites = 1'b1; opFlags = 1'b1; immVal = extendImm(imm8, 1'b1); end
        EXT_CMP: begin aluOp = ALU_CMP; opFlags = 1'b1; immVal = extendImm(imm8, 1'b1); end
        EXT_AND: begin aluOp = ALU_AND; opWrites = 1'b1; immVal = extendImm(imm8, 1'b0); end
        EXT_OR:  begin aluOp = ALU_OR;  opWrites = 1'b1; immVal = extendImm(imm8, 1'b0); end
        EXT_XOR: begin aluOp = ALU_XOR; opWrites = 1'b1; immVal = extendImm(imm8, 1'b0); end
        EXT_MOV: begin aluOp = ALU_PASS; opWrites = 1'b1; immVal = extendImm(imm8, 1'b0); end
        default: opLegal = 1'b0;
      endcase
    end
  end

  // RegFile reads are combinational, so operands are valid during EXECUTE.
  assign opA = rd_dst;
  assign opB = useImm ? immVal : rd_src;

  alu_core uAlu (
    .a      (opA),
    .b      (opB),
    .op     (aluOp),
    .result (aluResult),
    .flags  (aluFlags)
  );

  always_comb begin
    instr_ready = (state == IDLE);
    src_addr    = '0;
    dst_addr    = '0;
    reg_write   = 1'b0;
    wr_data     = '0;
    flags_out   = '0;
    flags_write = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    if (state != IDLE) begin
      src_addr = instrQ[3:0];
      dst_addr = instrQ[11:8];
    end
    if (state == WRITEBACK) begin
      reg_write   = opLegal && opWrites;
      wr_data     = resultQ;
      flags_out   = flagsQ;
      flags_write = opLegal && opFlags;
      done        = opLegal;
      illegal     = !opLegal;
    end
  end

endmodule
